// File: rtl/sc_speed_tick_gen.sv
// Programmable-period tick generator: divides the clock into one-cycle active-low
// count pulses, with run/pause/brake control and a saturating acceleration ramp.
module sc_speed_tick_gen #(
  parameter int unsigned PRESCALER_DATAWIDTH = 24,
  parameter int unsigned PERIOD_MAX          = 5000000,
  parameter int unsigned PERIOD_MIN          = 1000000,
  parameter int unsigned PERIOD_STEP         = 500000,
  parameter int unsigned RAMP_TICKS          = 8,
  parameter int unsigned RAMPCNT_WIDTH       = 4
) (
  input  logic                           SC_speedTICK_CLOCK_50,
  input  logic                           SC_speedTICK_RESET_InHigh,
  input  logic                           SC_speedTICK_run_InLow,
  input  logic                           SC_speedTICK_accel_InLow,
  input  logic                           SC_speedTICK_brake_InLow,
  output logic                           SC_speedTICK_upcount_OutLow,
  output logic [PRESCALER_DATAWIDTH-1:0] SC_speedTICK_period_OutBUS,
  output logic [1:0]                     SC_speedTICK_state_OutBUS
);

  localparam int unsigned W  = PRESCALER_DATAWIDTH;
  localparam int unsigned RW = RAMPCNT_WIDTH;

  localparam logic [W-1:0]  P_MAX      = W'(PERIOD_MAX);
  localparam logic [W-1:0]  P_MIN      = W'(PERIOD_MIN);
  localparam logic [W-1:0]  P_STEP     = W'(PERIOD_STEP);
  localparam logic [W:0]    SAT_THRESH = (W+1)'(PERIOD_MIN + PERIOD_STEP);
  localparam logic [RW-1:0] RAMP_LAST  = RW'(RAMP_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  presc_q, presc_d;
  logic [W-1:0]  period_q, period_d;
  logic [RW-1:0] ramp_q, ramp_d;
  logic          up_q, up_d;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    period_d = period_q;
    ramp_d   = ramp_q;
    up_d     = 1'b1;

    if (!SC_speedTICK_brake_InLow) begin
      state_d  = ST_IDLE;
      presc_d  = '0;
      period_d = P_MAX;
      ramp_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          presc_d = '0;
          if (!SC_speedTICK_run_InLow) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (SC_speedTICK_run_InLow) begin
            state_d = ST_PAUSE;
          end else if (presc_q == period_q - 1'b1) begin
            presc_d = '0;
            up_d    = 1'b0;
            // Period update lands on the tick edge, so the new interval starts with it.
            if (!SC_speedTICK_accel_InLow) begin
              if (ramp_q == RAMP_LAST) begin
                ramp_d   = '0;
                period_d = ({1'b0, period_q} >= SAT_THRESH) ? (period_q - P_STEP) : P_MIN;
              end else begin
                ramp_d = ramp_q + 1'b1;
              end
            end else begin
              ramp_d = '0;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (!SC_speedTICK_run_InLow) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge SC_speedTICK_CLOCK_50) begin
    if (SC_speedTICK_RESET_InHigh) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      period_q <= P_MAX;
      ramp_q   <= '0;
      up_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      period_q <= period_d;
      ramp_q   <= ramp_d;
      up_q     <= up_d;
    end
  end

  assign SC_speedTICK_upcount_OutLow = up_q;
  assign SC_speedTICK_period_OutBUS  = period_q;
  assign SC_speedTICK_state_OutBUS   = state_q;

endmodule
